// File: rtl/if_id_ex_pkg.sv
// rtl/if_id_ex_pkg.sv - shared field positions, control layout and IM image for the IF/ID/EX slice
// Optional feature macro used by this slice: IM_WRITE_PORT_EN
package if_id_ex_pkg;

  localparam int INSTR_W = 16;

  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 12;
  localparam int RS_MSB    = 11;
  localparam int RS_LSB    = 8;
  localparam int RT_MSB    = 7;
  localparam int RT_LSB    = 4;
  localparam int FUNCT_MSB = 3;
  localparam int FUNCT_LSB = 0;
  localparam int OFS_MSB   = 11;
  localparam int OFS_LSB   = 0;

  localparam int CTL_W         = 9;
  localparam int CTL_R15       = 8;
  localparam int CTL_ALU_SRC   = 7;
  localparam int CTL_MEM2REG   = 6;
  localparam int CTL_REG_WRITE = 5;
  localparam int CTL_MEM_READ  = 4;
  localparam int CTL_MEM_WRITE = 3;
  localparam int CTL_BRANCH    = 2;
  localparam int CTL_ALUOP_MSB = 1;
  localparam int CTL_ALUOP_LSB = 0;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  localparam int IM_MAX_WORDS = 128;
  localparam int IM_IDX_W     = 7;

  localparam logic [INSTR_W-1:0] IM_IMAGE [IM_MAX_WORDS] = '{
    0: 16'h1234,
    1: 16'h2B56,
    2: 16'hF00C,
    3: 16'h8FFF,
    default: 16'h0000
  };

  typedef struct packed {
    logic       r15;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctl_t;

endpackage

// File: rtl/if_id_ex_imem.sv
// rtl/if_id_ex_imem.sv - instruction memory: combinational ROM, or RAM with a write port under IM_WRITE_PORT_EN
module if_id_ex_imem
  import if_id_ex_pkg::*;
#(
  parameter int IM_WORDS = 128,
  parameter int ADDR_W   = 8
) (
`ifdef IM_WRITE_PORT_EN
  input  logic               clk,
  input  logic               reset,
  input  logic               im_we,
  input  logic [ADDR_W-1:0]  im_waddr,
  input  logic [INSTR_W-1:0] im_wdata,
`endif
  input  logic [ADDR_W-1:0]  addr,
  output logic [INSTR_W-1:0] rdata
);

  localparam int IDX_W   = ADDR_W - 1;
  localparam int WORD_AW = $clog2(IM_WORDS);

  logic [IDX_W-1:0] ridx;
  logic             unused_addr_lsb;

  assign ridx            = addr[ADDR_W-1:1];
  assign unused_addr_lsb = addr[0];

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return {{(32-IDX_W){1'b0}}, idx} < IM_WORDS;
  endfunction

`ifdef IM_WRITE_PORT_EN
  logic [INSTR_W-1:0] mem [IM_WORDS];
  logic [IDX_W-1:0]   widx;
  logic               unused_waddr_lsb;

  assign widx             = im_waddr[ADDR_W-1:1];
  assign unused_waddr_lsb = im_waddr[0];

  // Reset reloads the boot image so a patched program never survives a reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < IM_WORDS; i++) begin
        mem[i] <= IM_IMAGE[i];
      end
    end else if (im_we && in_range(widx)) begin
      mem[WORD_AW'(widx)] <= im_wdata;
    end
  end

  always_comb begin
    rdata = NOP_INSTR;
    if (in_range(ridx)) begin
      rdata = mem[WORD_AW'(ridx)];
    end
  end
`else
  always_comb begin
    rdata = NOP_INSTR;
    if (in_range(ridx)) begin
      rdata = IM_IMAGE[IM_IDX_W'(ridx)];
    end
  end
`endif

endmodule

// File: rtl/if_id_ex_pipe.sv
// rtl/if_id_ex_pipe.sv - IM fetch, IF/ID register with field decode, ID/EX operand/control register
// Optional write port into the IM is enabled by IM_WRITE_PORT_EN
module if_id_ex_pipe
  import if_id_ex_pkg::*;
#(
  parameter int IM_WORDS = 128,
  parameter int ADDR_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               ifid_write,
  input  logic               ifid_flush,
`ifdef IM_WRITE_PORT_EN
  input  logic               im_we,
  input  logic [ADDR_W-1:0]  im_waddr,
  input  logic [INSTR_W-1:0] im_wdata,
`endif
  output logic [INSTR_W-1:0] instr_if,
  output logic [INSTR_W-1:0] instr_id,
  output logic [ADDR_W-1:0]  pc_id,
  output logic [3:0]         opcode,
  output logic [3:0]         rs,
  output logic [3:0]         rt,
  output logic [3:0]         funct,
  output logic [11:0]        offset,
  input  logic               idex_flush,
  input  logic [INSTR_W-1:0] rd1,
  input  logic [INSTR_W-1:0] rd2,
  input  logic [INSTR_W-1:0] sext_in,
  input  logic [CTL_W-1:0]   ctl_in,
  output logic [INSTR_W-1:0] rd1_ex,
  output logic [INSTR_W-1:0] rd2_ex,
  output logic [INSTR_W-1:0] sext_ex,
  output logic [3:0]         funct_ex,
  output logic [3:0]         rs_ex,
  output logic [3:0]         rt_ex,
  output logic [CTL_W-1:0]   ctl_ex
);

  ctl_t ctl_q;

  if_id_ex_imem #(
    .IM_WORDS (IM_WORDS),
    .ADDR_W   (ADDR_W)
  ) u_imem (
`ifdef IM_WRITE_PORT_EN
    .clk      (clk),
    .reset    (reset),
    .im_we    (im_we),
    .im_waddr (im_waddr),
    .im_wdata (im_wdata),
`endif
    .addr     (pc),
    .rdata    (instr_if)
  );

  // Flush beats stall: a squashed slot must not keep a stale instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_id <= NOP_INSTR;
      pc_id    <= '0;
    end else if (ifid_flush) begin
      instr_id <= NOP_INSTR;
      pc_id    <= pc;
    end else if (ifid_write) begin
      instr_id <= instr_if;
      pc_id    <= pc;
    end
  end

  assign opcode = instr_id[OPC_MSB:OPC_LSB];
  assign rs     = instr_id[RS_MSB:RS_LSB];
  assign rt     = instr_id[RT_MSB:RT_LSB];
  assign funct  = instr_id[FUNCT_MSB:FUNCT_LSB];
  assign offset = instr_id[OFS_MSB:OFS_LSB];

  // A bubble only needs its control zeroed; operands flow through regardless.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd1_ex   <= '0;
      rd2_ex   <= '0;
      sext_ex  <= '0;
      funct_ex <= '0;
      rs_ex    <= '0;
      rt_ex    <= '0;
      ctl_q    <= '0;
    end else begin
      rd1_ex   <= rd1;
      rd2_ex   <= rd2;
      sext_ex  <= sext_in;
      funct_ex <= funct;
      rs_ex    <= rs;
      rt_ex    <= rt;
      ctl_q    <= idex_flush ? ctl_t'('0) : ctl_t'(ctl_in);
    end
  end

  assign ctl_ex = ctl_q;

endmodule

// File: tb/tb_if_id_ex_pipe.sv
// tb/tb_if_id_ex_pipe.sv - directed self-checking bench for if_id_ex_pipe (128-word and 64-word instances)
module tb_if_id_ex_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pc, pc_b;
  logic        ifid_write, ifid_flush, idex_flush;
  logic [15:0] rd1, rd2, sext_in;
  logic [8:0]  ctl_in;
`ifdef IM_WRITE_PORT_EN
  logic        im_we;
  logic [7:0]  im_waddr;
  logic [15:0] im_wdata;
  logic        im_we_b;
`endif

  logic [15:0] instr_if, instr_id, rd1_ex, rd2_ex, sext_ex;
  logic [7:0]  pc_id;
  logic [3:0]  opcode, rs, rt, funct, funct_ex, rs_ex, rt_ex;
  logic [11:0] offset;
  logic [8:0]  ctl_ex;

  logic [15:0] instr_if_b, instr_id_b, rd1_ex_b, rd2_ex_b, sext_ex_b;
  logic [7:0]  pc_id_b;
  logic [3:0]  opcode_b, rs_b, rt_b, funct_b, funct_ex_b, rs_ex_b, rt_ex_b;
  logic [11:0] offset_b;
  logic [8:0]  ctl_ex_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_ex_pipe #(.IM_WORDS(128), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .pc(pc), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
`ifdef IM_WRITE_PORT_EN
    .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
`endif
    .instr_if(instr_if), .instr_id(instr_id), .pc_id(pc_id), .opcode(opcode), .rs(rs), .rt(rt),
    .funct(funct), .offset(offset), .idex_flush(idex_flush), .rd1(rd1), .rd2(rd2),
    .sext_in(sext_in), .ctl_in(ctl_in), .rd1_ex(rd1_ex), .rd2_ex(rd2_ex), .sext_ex(sext_ex),
    .funct_ex(funct_ex), .rs_ex(rs_ex), .rt_ex(rt_ex), .ctl_ex(ctl_ex)
  );

  if_id_ex_pipe #(.IM_WORDS(64), .ADDR_W(8)) dut_b (
    .clk(clk), .reset(reset), .pc(pc_b), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
`ifdef IM_WRITE_PORT_EN
    .im_we(im_we_b), .im_waddr(im_waddr), .im_wdata(im_wdata),
`endif
    .instr_if(instr_if_b), .instr_id(instr_id_b), .pc_id(pc_id_b), .opcode(opcode_b), .rs(rs_b),
    .rt(rt_b), .funct(funct_b), .offset(offset_b), .idex_flush(idex_flush), .rd1(rd1), .rd2(rd2),
    .sext_in(sext_in), .ctl_in(ctl_in), .rd1_ex(rd1_ex_b), .rd2_ex(rd2_ex_b), .sext_ex(sext_ex_b),
    .funct_ex(funct_ex_b), .rs_ex(rs_ex_b), .rt_ex(rt_ex_b), .ctl_ex(ctl_ex_b)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    pc         = 8'($urandom);
    pc_b       = 8'($urandom);
    ifid_write = 1'($urandom);
    ifid_flush = 1'($urandom);
    idex_flush = 1'($urandom);
    rd1        = 16'($urandom);
    rd2        = 16'($urandom);
    sext_in    = 16'($urandom);
    ctl_in     = 9'($urandom);
`ifdef IM_WRITE_PORT_EN
    im_we      = 1'b0;
    im_waddr   = 8'h00;
    im_wdata   = 16'h0000;
    im_we_b    = 1'b0;
`endif
    repeat (3) step();
    chk("reset_instr_id", instr_id, 16'h0000);
    chk("reset_pc_id", 16'(pc_id), 16'h0000);
    chk("reset_ctl_ex", 16'(ctl_ex), 16'h0000);
    chk("reset_rd1_ex", rd1_ex, 16'h0000);
    chk("reset_sext_ex", sext_ex, 16'h0000);

    // Fetch sequence
    reset = 1'b1; pc = 8'h00; ifid_write = 1'b1; ifid_flush = 1'b0; idex_flush = 1'b0;
    rd1 = 16'h0000; rd2 = 16'h0000; sext_in = 16'h0000; ctl_in = 9'h000;
    #1;
    chk("instr_if_w0", instr_if, 16'h1234);
    step();
    chk("instr_id_w0", instr_id, 16'h1234);
    chk("opcode_w0", 16'(opcode), 16'h0001);
    chk("rs_w0", 16'(rs), 16'h0002);
    chk("rt_w0", 16'(rt), 16'h0003);
    chk("funct_w0", 16'(funct), 16'h0004);
    chk("offset_w0", 16'(offset), 16'h0234);
    chk("pc_id_w0", 16'(pc_id), 16'h0000);
    pc = 8'h02; step();
    chk("instr_id_w1", instr_id, 16'h2B56);
    chk("pc_id_w1", 16'(pc_id), 16'h0002);
    pc = 8'h03; step();
    chk("instr_id_odd_pc", instr_id, 16'h2B56);
    chk("pc_id_odd_pc", 16'(pc_id), 16'h0003);

    // Stall and flush
    pc = 8'h04; step();
    chk("instr_id_w2", instr_id, 16'hF00C);
    ifid_write = 1'b0; pc = 8'h06; step();
    chk("stall_instr_id", instr_id, 16'hF00C);
    chk("stall_pc_id", 16'(pc_id), 16'h0004);
    ifid_flush = 1'b1; step();
    chk("flush_instr_id", instr_id, 16'h0000);
    chk("flush_pc_id", 16'(pc_id), 16'h0006);
    ifid_write = 1'b1; pc = 8'h02; step();
    chk("flush_beats_write", instr_id, 16'h0000);
    ifid_flush = 1'b0;

    // Combinational reads and out-of-range words
    pc = 8'h06; #1;
    chk("instr_if_w3", instr_if, 16'h8FFF);
    pc = 8'h08; #1;
    chk("instr_if_w4_zero", instr_if, 16'h0000);
    pc = 8'hFE; #1;
    chk("instr_if_oor_128", instr_if, 16'h0000);
    pc_b = 8'h80; #1;
    chk("instr_if_oor_64", instr_if_b, 16'h0000);
    pc_b = 8'h05; #1;
    chk("instr_if_64_w2", instr_if_b, 16'hF00C);
    pc_b = 8'h81; #1;
    chk("instr_if_oor_64_odd", instr_if_b, 16'h0000);

    // ID/EX capture, with 16'h1234 sitting in IF/ID
    pc = 8'h00; step();
    rd1 = 16'hAAAA; rd2 = 16'h5555; sext_in = 16'hFFF0; ctl_in = 9'h1FF; step();
    chk("rd1_ex", rd1_ex, 16'hAAAA);
    chk("rd2_ex", rd2_ex, 16'h5555);
    chk("sext_ex", sext_ex, 16'hFFF0);
    chk("ctl_ex", 16'(ctl_ex), 16'h01FF);
    chk("funct_ex", 16'(funct_ex), 16'h0004);
    chk("rs_ex", 16'(rs_ex), 16'h0002);
    chk("rt_ex", 16'(rt_ex), 16'h0003);
    idex_flush = 1'b1; rd1 = 16'h1111; step();
    chk("idex_flush_ctl", 16'(ctl_ex), 16'h0000);
    chk("idex_flush_rd1", rd1_ex, 16'h1111);
    ifid_flush = 1'b1; rd1 = 16'h2222; ctl_in = 9'h0AA; step();
    chk("dual_flush_instr_id", instr_id, 16'h0000);
    chk("dual_flush_ctl", 16'(ctl_ex), 16'h0000);
    chk("dual_flush_rd1", rd1_ex, 16'h2222);
    ifid_flush = 1'b0; idex_flush = 1'b0; step();
    chk("ctl_after_flush", 16'(ctl_ex), 16'h00AA);
    chk("funct_ex_of_nop", 16'(funct_ex), 16'h0000);

    // Asynchronous reset between edges
    #2 reset = 1'b0;
    #1;
    chk("async_instr_id", instr_id, 16'h0000);
    chk("async_ctl_ex", 16'(ctl_ex), 16'h0000);
    chk("async_rd1_ex", rd1_ex, 16'h0000);
    #3 reset = 1'b1;
    pc = 8'h02; step();
    chk("post_reset_fetch", instr_id, 16'h2B56);

`ifdef IM_WRITE_PORT_EN
    im_we = 1'b1; im_waddr = 8'h04; im_wdata = 16'hBEEF; pc = 8'h04; #1;
    chk("rdw_old_data", instr_if, 16'hF00C);
    step();
    im_we = 1'b0; #1;
    chk("im_write_read", instr_if, 16'hBEEF);
    chk("im_write_id_old", instr_id, 16'hF00C);
    step();
    chk("im_write_id_new", instr_id, 16'hBEEF);
    im_we_b = 1'b1; im_waddr = 8'h80; im_wdata = 16'hDEAD; pc_b = 8'h00; step();
    im_we_b = 1'b0; #1;
    chk("oor_write_ignored", instr_if_b, 16'h1234);
    reset = 1'b0; #1;
    chk("im_reset_restore", instr_if, 16'hF00C);
    reset = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_ex_pipe.md
Name: if_id_ex_pipe

Overview:
Front-end pipeline slice of the 16-bit CPU. It holds the instruction memory (IM), the IF/ID pipeline register with its field decode, and the ID/EX pipeline register that carries register-file operands and control bits into EX. The PC/adder, control unit and register file sit outside and connect through the ports below.

Parameters:
- IM_WORDS, 128: number of 16-bit instruction words; must be a power of two, 128 or less.
- ADDR_W, 8: byte-address width of the PC.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- pc  in  ADDR_W  fetch byte address
- ifid_write  in  1  1 = IF/ID loads; 0 = IF/ID holds (stall)
- ifid_flush  in  1  load a NOP into IF/ID
- instr_if  out  16  combinational IM read data
- instr_id  out  16  registered instruction
- pc_id  out  ADDR_W  registered fetch address
- opcode  out  4  instr_id[15:12]
- rs  out  4  instr_id[11:8]
- rt  out  4  instr_id[7:4]
- funct  out  4  instr_id[3:0]
- offset  out  12  instr_id[11:0]
- idex_flush  in  1  insert a bubble into ID/EX
- rd1, rd2  in  16 each  register-file read data
- sext_in  in  16  sign-extended immediate
- ctl_in  in  9  {R15, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOP[1:0]}
- rd1_ex, rd2_ex, sext_ex  out  16 each  registered operands
- funct_ex, rs_ex, rt_ex  out  4 each  registered fields, taken from the IF/ID outputs
- ctl_ex  out  9  registered control, same bit order as ctl_in

Behaviour:
- IM is a combinational ROM. Word index = pc[ADDR_W-1:1]; pc[0] is ignored.
- An index ≥ IM_WORDS returns 16'h0000.
- IM contents come from the package constant IM_IMAGE.
- reset = 0 (asynchronous) clears every register to 0: instr_id, pc_id, all ID/EX fields.
- IF/ID register, on each rising edge while reset = 1:
  - ifid_flush = 1: instr_id ← 16'h0000, pc_id ← pc. Flush wins over stall.
  - else if ifid_write = 1: instr_id ← instr_if, pc_id ← pc.
  - else: hold.
- IF/ID latency is one cycle. Decoded fields are purely combinational slices of instr_id.
- ID/EX register, on each rising edge while reset = 1:
  - All data fields (rd1, rd2, sext, funct, rs, rt) always capture.
  - ctl_ex ← 9'b0 if idex_flush = 1, else ctl_in.
- ID/EX latency is one cycle. Flush zeroes control only; data still passes.
- Simultaneous ifid_flush and idex_flush act independently in the same edge.
- Reset asserted mid-operation clears the registers immediately, without waiting for clk. Release is synchronous to the next edge.
- No X on any output after reset.

Optional Feature:
- Macro IM_WRITE_PORT_EN.
- When defined, adds three ports:
  - im_we  in  1
  - im_waddr  in  ADDR_W (byte address)
  - im_wdata  in  16
- The IM becomes a RAM initialised from IM_IMAGE on reset.
- A write happens on the rising edge when im_we = 1, to word im_waddr[ADDR_W-1:1].
- Write addresses out of range are ignored.
- Read-during-write to the same word returns the old data in that cycle.
- When not defined, these ports do not exist and the IM is a pure ROM.

Decomposition:
- Package if_id_ex_pkg holds:
  - the instruction field position constants;
  - CTL_W = 9 and the control bit index constants;
  - NOP_INSTR = 16'h0000;
  - IM_IMAGE: word0 = 16'h1234, word1 = 16'h2B56, word2 = 16'hF00C, word3 = 16'h8FFF, remaining words 0.
- One sub-module, if_id_ex_imem (ROM, or RAM when IM_WRITE_PORT_EN is defined). Both pipeline registers stay in the top.

Test Plan:
1. Reset: hold reset = 0 with random inputs → instr_id = 0, pc_id = 0, ctl_ex = 0, rd1_ex = 0; outputs change without a clock edge.
2. Fetch: pc = 8'h00, then 8'h02, then 8'h03, with ifid_write = 1 →
   - instr_id = 16'h1234 one cycle after pc = 8'h00 (opcode = 1, rs = 2, rt = 3, funct = 4, offset = 12'h234, pc_id = 8'h00);
   - then 16'h2B56;
   - pc = 8'h03 yields 16'h2B56 (bit 0 ignored).
3. Stall/flush: after word2 (16'hF00C) is loaded, set ifid_write = 0 → holds 16'hF00C; then ifid_flush = 1 with ifid_write = 0 → instr_id = 16'h0000.
4. Out of range: with IM_WORDS = 128, pc = 8'hFE → instr_if = 16'h0000. With IM_WORDS = 64, pc = 8'h80 → 16'h0000.
5. ID/EX: rd1 = 16'hAAAA, rd2 = 16'h5555, sext = 16'hFFF0, ctl_in = 9'h1FF →
   - next edge: rd1_ex = 16'hAAAA, ctl_ex = 9'h1FF;
   - with idex_flush = 1: ctl_ex = 0 and rd1_ex is still updated.
6. IM_WRITE_PORT_EN defined: write 16'hBEEF to address 8'h04 → pc = 8'h04 reads 16'hBEEF the next cycle; reset restores 16'hF00C.
